// File: rtl/mem_stage_if.sv
// mem_stage_if: execute-side input, data-memory bus and writeback handshake of the Y86 memory stage.
// slave is the stage's own view; master is the surrounding pipeline/memory view.
interface mem_stage_if;
  // Execute-side instruction input
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  icode_i;
  logic [7:0]  stat_i;
  logic [31:0] valE_i;
  logic [31:0] valA_i;
  logic [31:0] valP_i;
  logic [7:0]  dstE_i;
  logic [7:0]  dstM_i;

  // Data-memory req/ack bus
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        mem_err_i;

  // Writeback result
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  icode_o;
  logic [7:0]  stat_o;
  logic [31:0] valE_o;
  logic [31:0] valM_o;
  logic [7:0]  dstE_o;
  logic [7:0]  dstM_o;

  modport slave (
    input  valid_i, icode_i, stat_i, valE_i, valA_i, valP_i, dstE_i, dstM_i,
    input  mem_rdata_i, mem_ack_i, mem_err_i, ready_i,
    output ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output valid_o, icode_o, stat_o, valE_o, valM_o, dstE_o, dstM_o
  );

  modport master (
    output valid_i, icode_i, stat_i, valE_i, valA_i, valP_i, dstE_i, dstM_i,
    output mem_rdata_i, mem_ack_i, mem_err_i, ready_i,
    input  ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  valid_o, icode_o, stat_o, valE_o, valM_o, dstE_o, dstM_o
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: Y86 memory stage. Accepts an execute result, performs the data-memory
// read/write over a req/ack bus (with timeout), and hands the result to writeback.
// Optional macro MEM_ALIGN_CHECK_EN: unaligned accesses fail with STAT_ADR and never reach the bus.
module mem_stage #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter logic [7:0]  STAT_AOK    = 8'd1,
  parameter logic [7:0]  STAT_ADR    = 8'd3
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 8;

  localparam logic [BW-1:0] I_RMMOVL = 8'h04;
  localparam logic [BW-1:0] I_MRMOVL = 8'h05;
  localparam logic [BW-1:0] I_CALL   = 8'h08;
  localparam logic [BW-1:0] I_RET    = 8'h09;
  localparam logic [BW-1:0] I_PUSHL  = 8'h0A;
  localparam logic [BW-1:0] I_POPL   = 8'h0B;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic             valid_q, valid_d;
  logic [DW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    vale_q, vale_d;
  logic [DW-1:0]    valm_q, valm_d;
  logic [BW-1:0]    icode_q, icode_d;
  logic [BW-1:0]    stat_q, stat_d;
  logic [BW-1:0]    dste_q, dste_d;
  logic [BW-1:0]    dstm_q, dstm_d;

  logic             dec_acc;
  logic             dec_we;
  logic [DW-1:0]    dec_addr;
  logic [DW-1:0]    dec_wdata;
  logic             dec_misaligned;
  logic             ready_c;
  logic             accept;

  // Decode the memory access an incoming instruction requires
  always_comb begin
    dec_acc   = 1'b0;
    dec_we    = 1'b0;
    dec_addr  = bus.valE_i;
    dec_wdata = bus.valA_i;
    if (bus.stat_i == STAT_AOK) begin
      case (bus.icode_i)
        I_RMMOVL, I_PUSHL: begin
          dec_acc = 1'b1;
          dec_we  = 1'b1;
        end
        I_CALL: begin
          dec_acc   = 1'b1;
          dec_we    = 1'b1;
          dec_wdata = bus.valP_i;
        end
        I_MRMOVL: dec_acc = 1'b1;
        I_POPL, I_RET: begin
          dec_acc  = 1'b1;
          dec_addr = bus.valA_i;
        end
        default: dec_acc = 1'b0;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign dec_misaligned = dec_acc && (dec_addr[1:0] != 2'b00);
`else
  assign dec_misaligned = 1'b0;
`endif

  // A new instruction can enter when idle, or when the held result leaves this cycle
  assign ready_c = (state_q == IDLE) || ((state_q == DONE) && bus.ready_i);
  assign accept  = bus.valid_i && ready_c;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    vale_d  = vale_q;
    valm_d  = valm_q;
    icode_d = icode_q;
    stat_d  = stat_q;
    dste_d  = dste_q;
    dstm_d  = dstm_q;

    case (state_q)
      IDLE: state_d = IDLE;
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.mem_ack_i) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
          valm_d  = we_q ? '0 : bus.mem_rdata_i;
          if (bus.mem_err_i) begin
            stat_d = STAT_ADR;
            valm_d = '0;
          end
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          valid_d = 1'b1;
          stat_d  = STAT_ADR;
          valm_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Acceptance overrides the IDLE/DONE bookkeeping above
    if (accept) begin
      icode_d = bus.icode_i;
      stat_d  = bus.stat_i;
      vale_d  = bus.valE_i;
      dste_d  = bus.dstE_i;
      dstm_d  = bus.dstM_i;
      valm_d  = '0;
      cnt_d   = '0;
      if (dec_misaligned) begin
        stat_d  = STAT_ADR;
        valid_d = 1'b1;
        state_d = DONE;
      end else if (dec_acc) begin
        req_d   = 1'b1;
        we_d    = dec_we;
        addr_d  = dec_addr;
        wdata_d = dec_wdata;
        valid_d = 1'b0;
        state_d = ACCESS;
      end else begin
        valid_d = 1'b1;
        state_d = DONE;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      vale_q  <= '0;
      valm_q  <= '0;
      icode_q <= '0;
      stat_q  <= STAT_AOK;
      dste_q  <= '0;
      dstm_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      vale_q  <= vale_d;
      valm_q  <= valm_d;
      icode_q <= icode_d;
      stat_q  <= stat_d;
      dste_q  <= dste_d;
      dstm_q  <= dstm_d;
    end
  end

  assign bus.ready_o     = ready_c;
  assign bus.mem_req_o   = req_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.valid_o     = valid_q;
  assign bus.icode_o     = icode_q;
  assign bus.stat_o      = stat_q;
  assign bus.valE_o      = vale_q;
  assign bus.valM_o      = valm_q;
  assign bus.dstE_o      = dste_q;
  assign bus.dstM_o      = dstm_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized bench for mem_stage with a transaction-level
// reference model and a scripted/random memory responder.
module tb_mem_stage;

  localparam int unsigned TIMEOUT  = 255;
  localparam logic [7:0]  STAT_AOK = 8'd1;
  localparam logic [7:0]  STAT_ADR = 8'd3;

  logic clk;
  logic rst;
  mem_stage_if bus ();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Responder controls
  bit          resp_random;
  int          resp_delay;
  bit          resp_err;
  logic [31:0] resp_rdata;

  // Model of the in-flight instruction
  bit          m_have, m_wait, m_take;
  int          m_cnt;
  bit          m_acc, m_we, m_mis;
  logic [31:0] m_addr, m_wdata, m_valE, m_valM;
  logic [7:0]  m_icode, m_stat, m_dstE, m_dstM;

  // Memory access demanded by an instruction, straight from the ISA rules
  function automatic void spec_decode(input logic [7:0] ic, input logic [7:0] st,
                                      input logic [31:0] ve, input logic [31:0] va,
                                      input logic [31:0] vp, output bit acc, output bit we,
                                      output logic [31:0] addr, output logic [31:0] wd);
    acc = 1'b0; we = 1'b0; addr = ve; wd = va;
    if (st == STAT_AOK) begin
      case (ic)
        8'h04, 8'h0A: begin acc = 1'b1; we = 1'b1; end
        8'h08:        begin acc = 1'b1; we = 1'b1; wd = vp; end
        8'h05:        acc = 1'b1;
        8'h09, 8'h0B: begin acc = 1'b1; addr = va; end
        default:      acc = 1'b0;
      endcase
    end
  endfunction

  // Reference model: advances one instruction's life each clock
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_have = 1'b0;
      m_wait = 1'b0;
      m_cnt  = 0;
    end else begin
      m_take = bus.valid_i && (!m_have || (!m_wait && bus.ready_i));
      if (m_have && m_wait) begin
        m_cnt = m_cnt + 1;
        if (bus.mem_ack_i) begin
          m_wait = 1'b0;
          if (!m_we) m_valM = bus.mem_rdata_i;
          if (bus.mem_err_i) begin
            m_stat = STAT_ADR;
            m_valM = 32'h0;
          end
        end else if (m_cnt == int'(TIMEOUT)) begin
          m_wait = 1'b0;
          m_stat = STAT_ADR;
        end
      end else if (m_have && bus.ready_i) begin
        m_have = 1'b0;
      end
      if (m_take) begin
        spec_decode(bus.icode_i, bus.stat_i, bus.valE_i, bus.valA_i, bus.valP_i,
                    m_acc, m_we, m_addr, m_wdata);
`ifdef MEM_ALIGN_CHECK_EN
        m_mis = m_acc && (m_addr[1:0] != 2'b00);
`else
        m_mis = 1'b0;
`endif
        m_have  = 1'b1;
        m_icode = bus.icode_i;
        m_stat  = m_mis ? STAT_ADR : bus.stat_i;
        m_valE  = bus.valE_i;
        m_dstE  = bus.dstE_i;
        m_dstM  = bus.dstM_i;
        m_valM  = 32'h0;
        m_cnt   = 0;
        m_wait  = m_acc && !m_mis;
      end
    end
  end

  // Memory responder: scripted ack on the Nth request cycle, or random noise
  int req_cycles;
  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_err_i   = 1'b0;
    bus.mem_rdata_i = 32'h0;
    req_cycles      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_random) begin
        bus.mem_ack_i   = ($urandom % 3) == 0;
        bus.mem_err_i   = ($urandom % 8) == 0;
        bus.mem_rdata_i = $urandom;
      end else begin
        if (bus.mem_req_o) req_cycles = req_cycles + 1;
        else               req_cycles = 0;
        bus.mem_ack_i   = bus.mem_req_o && (resp_delay != 0) && (req_cycles == resp_delay);
        bus.mem_err_i   = bus.mem_ack_i && resp_err;
        bus.mem_rdata_i = resp_rdata;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every meaningful DUT output against the model
  task automatic compare();
    bit exp_ready;
    if (!rst) begin
      chk("rst_valid_o", 32'(bus.valid_o), 32'd0);
      chk("rst_mem_req_o", 32'(bus.mem_req_o), 32'd0);
      chk("rst_mem_we_o", 32'(bus.mem_we_o), 32'd0);
      chk("rst_stat_o", 32'(bus.stat_o), 32'(STAT_AOK));
      chk("rst_valE_o", bus.valE_o, 32'd0);
      chk("rst_valM_o", bus.valM_o, 32'd0);
      chk("rst_addr", bus.mem_addr_o, 32'd0);
      chk("rst_dst", {16'h0, bus.dstE_o, bus.dstM_o}, 32'd0);
    end else begin
      exp_ready = !m_have || (!m_wait && bus.ready_i);
      chk("ready_o", 32'(bus.ready_o), 32'(exp_ready));
      chk("valid_o", 32'(bus.valid_o), 32'(m_have && !m_wait));
      chk("mem_req_o", 32'(bus.mem_req_o), 32'(m_have && m_wait));
      if (m_have && m_wait) begin
        chk("mem_addr_o", bus.mem_addr_o, m_addr);
        chk("mem_we_o", 32'(bus.mem_we_o), 32'(m_we));
        if (m_we) chk("mem_wdata_o", bus.mem_wdata_o, m_wdata);
      end
      if (m_have && !m_wait) begin
        chk("icode_o", 32'(bus.icode_o), 32'(m_icode));
        chk("stat_o", 32'(bus.stat_o), 32'(m_stat));
        chk("valE_o", bus.valE_o, m_valE);
        chk("valM_o", bus.valM_o, m_valM);
        chk("dstE_o", 32'(bus.dstE_o), 32'(m_dstE));
        chk("dstM_o", 32'(bus.dstM_o), 32'(m_dstM));
      end
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    compare();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    to_neg();
    to_pos();
  endtask

  // Present an instruction until accepted; reports whether a result was leaving at acceptance
  task automatic issue(input logic [7:0] ic, input logic [7:0] st, input logic [31:0] ve,
                       input logic [31:0] va, input logic [31:0] vp, input logic [7:0] de,
                       input logic [7:0] dm, output bit acc_valid);
    bit got;
    got = 1'b0;
    acc_valid = 1'b0;
    bus.valid_i = 1'b1;
    bus.icode_i = ic; bus.stat_i = st;
    bus.valE_i = ve; bus.valA_i = va; bus.valP_i = vp;
    bus.dstE_i = de; bus.dstM_i = dm;
    for (int i = 0; i < 600 && !got; i++) begin
      to_neg();
      if (bus.ready_o) begin
        got = 1'b1;
        acc_valid = bus.valid_o;
      end
      to_pos();
    end
    bus.valid_i = 1'b0;
    chk("accept", 32'(got), 32'd1);
  endtask

  // Run until valid_o, counting request cycles; returns at the negedge where valid_o is seen
  task automatic wait_valid(output int n, output logic [31:0] last_addr);
    bit seen;
    seen = 1'b0;
    n = 0;
    last_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 600 && !seen; i++) begin
      to_neg();
      if (bus.valid_o) seen = 1'b1;
      else begin
        if (bus.mem_req_o) begin
          n = n + 1;
          last_addr = bus.mem_addr_o;
        end
        to_pos();
      end
    end
    chk("valid_seen", 32'(seen), 32'd1);
  endtask

  logic [7:0] icodes [12];

  initial begin
    bit          av;
    int          n;
    logic [31:0] la;
    checks = 0;
    errors = 0;
    resp_random = 1'b0;
    resp_delay  = 1;
    resp_err    = 1'b0;
    resp_rdata  = 32'h0;
    for (int i = 0; i < 12; i++) icodes[i] = 8'(i);
    rst = 1'b0;
    bus.valid_i = 1'b0; bus.ready_i = 1'b1;
    bus.icode_i = 8'h0; bus.stat_i = STAT_AOK;
    bus.valE_i = 32'h0; bus.valA_i = 32'h0; bus.valP_i = 32'h0;
    bus.dstE_i = 8'h0; bus.dstM_i = 8'h0;
    cyc();
    cyc();
    @(posedge clk); #3; rst = 1'b1;
    cyc();

    // IRMOVL: result one cycle after acceptance, no bus traffic
    issue(8'h03, STAT_AOK, 32'h1234, 32'h0, 32'h0, 8'h02, 8'h0F, av);
    to_neg();
    chk("irmovl_valid", 32'(bus.valid_o), 32'd1);
    chk("irmovl_valE", bus.valE_o, 32'h1234);
    chk("irmovl_valM", bus.valM_o, 32'h0);
    chk("irmovl_stat", 32'(bus.stat_o), 32'd1);
    chk("irmovl_req", 32'(bus.mem_req_o), 32'd0);
    to_pos();

    // MRMOVL: ack on the third request cycle
    resp_delay = 3; resp_rdata = 32'hDEAD_BEEF;
    issue(8'h05, STAT_AOK, 32'h100, 32'h0, 32'h0, 8'h0F, 8'h03, av);
    wait_valid(n, la);
    chk("mrmovl_req_cycles", 32'(n), 32'd3);
    chk("mrmovl_addr", la, 32'h100);
    chk("mrmovl_valM", bus.valM_o, 32'hDEAD_BEEF);
    to_pos();

    // CALL write followed by a back-to-back IRMOVL accepted in the DONE cycle
    resp_delay = 1;
    issue(8'h08, STAT_AOK, 32'hFC, 32'h11, 32'h40, 8'h04, 8'h0F, av);
    to_neg();
    chk("call_addr", bus.mem_addr_o, 32'hFC);
    chk("call_we", 32'(bus.mem_we_o), 32'd1);
    chk("call_wdata", bus.mem_wdata_o, 32'h40);
    to_pos();
    issue(8'h03, STAT_AOK, 32'h77, 32'h0, 32'h0, 8'h01, 8'h0F, av);
    chk("b2b_accept_in_done", 32'(av), 32'd1);
    to_neg();
    chk("b2b_valid", 32'(bus.valid_o), 32'd1);
    chk("b2b_valE", bus.valE_o, 32'h77);
    to_pos();

    // POPL with bus error
    resp_delay = 2; resp_err = 1'b1; resp_rdata = 32'h1111_2222;
    issue(8'h0B, STAT_AOK, 32'h0, 32'h200, 32'h0, 8'h04, 8'h05, av);
    wait_valid(n, la);
    chk("popl_err_addr", la, 32'h200);
    chk("popl_err_stat", 32'(bus.stat_o), 32'd3);
    chk("popl_err_valM", bus.valM_o, 32'h0);
    to_pos();
    resp_err = 1'b0;

    // POPL with no ack: request held exactly TIMEOUT cycles
    resp_delay = 0;
    issue(8'h0B, STAT_AOK, 32'h0, 32'h300, 32'h0, 8'h04, 8'h05, av);
    wait_valid(n, la);
    chk("timeout_req_cycles", 32'(n), 32'd255);
    chk("timeout_stat", 32'(bus.stat_o), 32'd3);
    chk("timeout_valM", bus.valM_o, 32'h0);
    to_pos();

    // Ack on the final permitted cycle wins over the timeout
    resp_delay = 255; resp_rdata = 32'h5A5A_5A5A;
    issue(8'h05, STAT_AOK, 32'h400, 32'h0, 32'h0, 8'h0F, 8'h06, av);
    wait_valid(n, la);
    chk("ack_at_limit_cycles", 32'(n), 32'd255);
    chk("ack_at_limit_stat", 32'(bus.stat_o), 32'd1);
    chk("ack_at_limit_valM", bus.valM_o, 32'h5A5A_5A5A);
    to_pos();

    // Writeback stalls for five cycles: result held, no new acceptance
    bus.ready_i = 1'b0;
    issue(8'h03, STAT_AOK, 32'h55, 32'h0, 32'h0, 8'h07, 8'h0F, av);
    for (int k = 0; k < 5; k++) begin
      to_neg();
      chk("stall_valid", 32'(bus.valid_o), 32'd1);
      chk("stall_valE", bus.valE_o, 32'h55);
      chk("stall_ready_o", 32'(bus.ready_o), 32'd0);
      to_pos();
    end
    bus.ready_i = 1'b1;
    cyc();

    // Reset in the middle of a pending read
    resp_delay = 0;
    issue(8'h05, STAT_AOK, 32'h500, 32'h0, 32'h0, 8'h0F, 8'h02, av);
    cyc();
    cyc();
    @(posedge clk); #3; rst = 1'b0; #1;
    chk("midrst_req", 32'(bus.mem_req_o), 32'd0);
    chk("midrst_valid", 32'(bus.valid_o), 32'd0);
    to_neg();
    @(posedge clk); #3; rst = 1'b1;
    cyc();
    cyc();

    // Unaligned RMMOVL
    resp_delay = 2;
    issue(8'h04, STAT_AOK, 32'h102, 32'hAB, 32'h0, 8'h0F, 8'h0F, av);
    wait_valid(n, la);
`ifdef MEM_ALIGN_CHECK_EN
    chk("unaligned_req_cycles", 32'(n), 32'd0);
    chk("unaligned_stat", 32'(bus.stat_o), 32'd3);
`else
    chk("unaligned_req_cycles", 32'(n), 32'd2);
    chk("unaligned_addr", la, 32'h102);
    chk("unaligned_stat", 32'(bus.stat_o), 32'd1);
`endif
    to_pos();

    // Randomized traffic with a noisy responder
    resp_random = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      bus.valid_i = ($urandom % 2) == 0;
      bus.icode_i = icodes[$urandom % 12];
      bus.stat_i  = (($urandom % 5) == 0) ? 8'($urandom % 8) : STAT_AOK;
      bus.valE_i  = (($urandom % 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      bus.valA_i  = (($urandom % 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      bus.valP_i  = $urandom;
      bus.dstE_i  = 8'($urandom);
      bus.dstM_i  = 8'($urandom);
      bus.ready_i = ($urandom % 4) != 0;
      cyc();
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int c = 0; c < 40; c++) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Y86 memory stage. Sits directly downstream of the execute stage and consumes its valE_o/dstE_o together with the forwarded valA, valP, dstM and status.
- Performs the data-memory read or write required by the instruction over a req/ack memory bus, holding the access stable until it completes.
- Delivers valE, valM, dstE, dstM and the updated status to writeback through a valid/ready handshake.

Parameters:
- MEM_TIMEOUT, 255: cycles to wait for mem_ack_i before aborting with ADR. Legal range 1..65535.
- STAT_AOK, 1: status code for OK.
- STAT_ADR, 3: status code for address error.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  execute result valid.
- ready_o  out  1  stage can accept a new instruction.
- icode_i  in  8  instruction code.
- stat_i  in  8  incoming status.
- valE_i  in  32  ALU result from execute.
- valA_i  in  32  operand A.
- valP_i  in  32  next PC, used as the return address for CALL.
- dstE_i  in  8  register destination for E.
- dstM_i  in  8  register destination for M.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  byte address.
- mem_wdata_o  out  32  write data.
- mem_rdata_i  in  32  read data, valid while mem_ack_i is high.
- mem_ack_i  in  1  access complete.
- mem_err_i  in  1  bus error, sampled together with ack.
- valid_o  out  1  result valid to writeback.
- ready_i  in  1  writeback accepts.
- icode_o  out  8  registered icode.
- stat_o  out  8  registered status.
- valE_o  out  32  registered valE.
- valM_o  out  32  registered memory read data.
- dstE_o  out  8  registered dstE.
- dstM_o  out  8  registered dstM.

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE.
  - All data outputs 0, stat_o = STAT_AOK.
  - valid_o, mem_req_o, mem_we_o = 0.
  - Timeout counter 0.
  - Any in-flight access is abandoned with no retry after reset.
- Access decode, applied only when stat_i == STAT_AOK:
  - RMMOVL (4), PUSHL (A): write, addr = valE_i, data = valA_i.
  - CALL (8): write, addr = valE_i, data = valP_i.
  - MRMOVL (5): read, addr = valE_i.
  - POPL (B), RET (9): read, addr = valA_i.
  - All other icodes: no access.
  - stat_i != STAT_AOK: no access regardless of icode.
- State IDLE:
  - ready_o = 1.
  - valid_i high: latch all inputs. Go to ACCESS if an access is needed, else DONE with valM_o = 0.
- State ACCESS:
  - mem_req_o = 1. addr, we and wdata come from the latches and stay stable for the whole request.
  - Counter increments each cycle.
  - On mem_ack_i:
    - Read: valM_o = mem_rdata_i.
    - mem_err_i also high: stat_o = STAT_ADR and valM_o = 0.
    - mem_req_o deasserts the following cycle; go to DONE.
  - Counter reaches MEM_TIMEOUT with no ack: stat_o = STAT_ADR, drop the request, go to DONE.
  - An ack on the same cycle as the timeout takes precedence over the timeout.
- State DONE:
  - valid_o = 1; outputs are held stable.
  - On ready_i: valid_o falls.
  - ready_o = ready_i, so a new instruction may be accepted in the same cycle (back-to-back). If one is accepted, the next state is ACCESS or DONE according to its decode; otherwise IDLE.
- Latency:
  - Non-memory instruction: valid_o one cycle after acceptance.
  - Memory instruction: valid_o one cycle after the mem_ack_i cycle.
- Outside IDLE/DONE-with-ready, ready_o = 0 and valid_i is ignored.
- The counter clears on entry to ACCESS.
- mem_ack_i while not in ACCESS is ignored.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: an access whose address[1:0] != 0 issues no bus request; stat_o = STAT_ADR; go directly to DONE.
- Undefined: no alignment check; unaligned addresses go to the bus unchanged.

Test Plan:
- IRMOVL (3), valE_i=0x1234, dstE_i=2: valid_o one cycle later, valE_o=0x1234, valM_o=0, stat_o=1, mem_req_o never asserted.
- MRMOVL, valE_i=0x100, ack after 3 cycles with rdata 0xDEADBEEF: mem_addr_o=0x100 and mem_we_o=0 stable while requesting; valM_o=0xDEADBEEF.
- CALL, valE_i=0xFC, valP_i=0x40: write with addr 0xFC, wdata 0x40; then two back-to-back instructions with ready_i held high, second accepted in the DONE cycle.
- POPL, valA_i=0x200, ack with mem_err_i=1: stat_o=3, valM_o=0. Separately, no ack for 255 cycles: stat_o=3, request dropped.
- ready_i held low for 5 cycles in DONE: outputs stable, ready_o=0. Then rst pulsed low mid-ACCESS: mem_req_o and valid_o drop to 0 immediately.
- With MEM_ALIGN_CHECK_EN defined, RMMOVL valE_i=0x102: no request, stat_o=3. Undefined: request issued at 0x102.
